instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Major-state timing generator for the PDP-8 core: runs Fetch, Defer and Execute for each instruction.
- Drives the one-cycle strobes the program counter consumes: PC_FETCH, PC_CK, PC_LD and PC_LATCH.
- Also drives the memory request handshake and the IR load strobe.
- Sits between the front-panel RUN/STEP controls, the instruction register and the ProgramCounter/memory blocks.

Parameters:
- AUTORUN, 0, when 1 the block leaves reset behaving as if RUN were high until the first END state.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- RUN  in  1  level; run continuously while high
- STEP  in  1  rising edge executes one instruction while halted
- HALT_REQ  in  1  HLT decoded by datapath; sampled in END
- OPCODE  in  3  IR[11:9]
- IND  in  1  IR[8] indirect bit
- SKIP  in  1  skip condition from datapath; sampled in E_SKIP
- MEM_DONE  in  1  memory transaction complete
- MEM_REQ  out  1  memory transaction request
- MEM_WR  out  1  1 = write; valid while MEM_REQ is high
- IR_LD  out  1  load IR from memory data
- PC_FETCH  out  1  PC latch-and-increment strobe
- PC_CK  out  1  PC increment strobe
- PC_LD  out  1  PC load-from-bus strobe
- PC_LATCH  out  1  qualifies PC_CK to update PCLAT
- STATE  out  2  major state: 00 halt, 01 fetch, 10 defer, 11 execute
- RUNNING  out  1  high in every state except HALT

Behaviour:
- Async reset:
  - Forces state to HALT and all outputs to 0.
  - Clears the STEP edge register.
  - Reset mid-instruction abandons the instruction; no strobe completes.
- States: HALT, F_PC, F_MEM, DECODE, D_MEM, E_RD, E_WR, E_PC1, E_GAP, E_PC2, E_SKIP, END.
- Outputs are registered (Moore). Every strobe is high exactly one cycle, in its designated state.
- At most one PC strobe is high per cycle. Any PC strobe is followed by at least one low cycle before the next PC strobe.
- HALT:
  - RUN=1 → F_PC.
  - STEP rising edge (registered edge detect) → F_PC, with single-instruction flag set.
  - Otherwise stay in HALT.
- F_PC: PC_FETCH=1 → F_MEM.
- Memory states (F_MEM, D_MEM, E_RD, E_WR):
  - MEM_REQ=1; MEM_WR=1 only in E_WR.
  - Remain in the state until MEM_DONE is sampled high; leave on the next edge.
  - MEM_DONE outside memory states is ignored.
  - F_MEM: IR_LD=1 in the cycle MEM_DONE is seen, then → DECODE.
- DECODE (1 cycle):
  - OPCODE 6/7 → E_SKIP.
  - IND=1 and OPCODE 0–5 → D_MEM.
  - Otherwise route to the execute path below.
- D_MEM done → execute path below.
- Execute path by OPCODE:
  - 0 AND, 1 TAD: E_RD → END.
  - 2 ISZ: E_RD → E_WR → E_SKIP.
  - 3 DCA: E_WR → END.
  - 4 JMS: E_WR → E_PC1 → E_GAP → E_PC2 → END.
  - 5 JMP: E_PC1 → END.
- E_PC1: PC_LD=1.
- E_GAP: all strobes 0.
- E_PC2: PC_CK=1 and PC_LATCH=1 together.
- E_SKIP: if SKIP=1, PC_CK=1 with PC_LATCH=0; → END.
- END (1 cycle, no strobes):
  - HALT_REQ=1 → HALT.
  - Single-instruction flag set → HALT, clear flag.
  - RUN=0 → HALT.
  - Otherwise → F_PC.
- RUN dropping mid-instruction never truncates the instruction; the block halts at END.
- STEP held high runs exactly one instruction; it needs a fresh 0→1 edge to run another. STEP is ignored while not in HALT.
- STATE encoding:
  - 01: F_PC, F_MEM, DECODE.
  - 10: D_MEM.
  - 11: E_* states and END.
  - 00: HALT.

Test Plan:
- JMP direct (OPCODE=5, IND=0), RUN=1, MEM_DONE tied 1, after reset → PC_FETCH cycle 1; MEM_REQ+IR_LD cycle 2; PC_LD cycle 4; next PC_FETCH cycle 6.
- DCA indirect (OPCODE=3, IND=1), MEM_DONE delayed 3 cycles per request → STATE=10 during D_MEM; E_WR holds MEM_REQ=1 and MEM_WR=1 for 4 cycles; no PC strobe in execute.
- ISZ (OPCODE=2) with SKIP=1 → read then write transaction, one PC_CK pulse with PC_LATCH=0; repeat with SKIP=0 → no PC_CK.
- JMS (OPCODE=4) → MEM_WR transaction, PC_LD pulse, one all-low cycle, then PC_CK and PC_LATCH high in the same cycle; never two PC strobes adjacent.
- RUN=0, STEP held high 20 cycles → exactly one PC_FETCH, back in HALT with RUNNING=0; second STEP edge → one more instruction. Same flow with HALT_REQ=1 at END while RUN=1 → HALT.
- RESET pulsed mid F_MEM, between clock edges → MEM_REQ, RUNNING and STATE go to 0 immediately without waiting for CLK; RUN still high after release → restart at F_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// PDP-8 major-state sequencer: walks Fetch/Defer/Execute per instruction
// and issues the PC, memory and IR strobes from registered state.
module instr_sequencer #(
    parameter logic AUTORUN = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RUN,
    input  logic       STEP,
    input  logic       HALT_REQ,
    input  logic [2:0] OPCODE,
    input  logic       IND,
    input  logic       SKIP,
    input  logic       MEM_DONE,
    output logic       MEM_REQ,
    output logic       MEM_WR,
    output logic       IR_LD,
    output logic       PC_FETCH,
    output logic       PC_CK,
    output logic       PC_LD,
    output logic       PC_LATCH,
    output logic [1:0] STATE,
    output logic       RUNNING
);

    typedef enum logic [3:0] {
        S_HALT,
        S_F_PC,
        S_F_MEM,
        S_DECODE,
        S_D_MEM,
        S_E_RD,
        S_E_WR,
        S_E_PC1,
        S_E_GAP,
        S_E_PC2,
        S_E_SKIP,
        S_END
    } state_t;

    state_t     state_q, state_d;
    logic       single_q, single_d;
    logic       autorun_q, autorun_d;
    logic       step_q;
    logic       mem_req_q, mem_wr_q;
    logic       ir_ld_en_q, skip_en_q;
    logic       pc_fetch_q, pc_ck_q, pc_ld_q, pc_latch_q;
    logic [1:0] state_grp_q;
    logic       running_q;

    logic step_edge;
    logic run_eff;

    assign step_edge = STEP & ~step_q;
    assign run_eff   = RUN | autorun_q;

    function automatic state_t exec_entry(input logic [2:0] op);
        state_t s;
        unique case (op)
            3'd0, 3'd1, 3'd2: s = S_E_RD;
            3'd3, 3'd4:       s = S_E_WR;
            3'd5:             s = S_E_PC1;
            default:          s = S_E_SKIP;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] state_grp(input state_t s);
        logic [1:0] g;
        unique case (s)
            S_HALT:                       g = 2'b00;
            S_F_PC, S_F_MEM, S_DECODE:    g = 2'b01;
            S_D_MEM:                      g = 2'b10;
            default:                      g = 2'b11;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d   = state_q;
        single_d  = single_q;
        autorun_d = autorun_q;
        unique case (state_q)
            S_HALT: begin
                if (run_eff) begin
                    state_d  = S_F_PC;
                    single_d = 1'b0;
                end else if (step_edge) begin
                    state_d  = S_F_PC;
                    single_d = 1'b1;
                end
            end
            S_F_PC:   state_d = S_F_MEM;
            S_F_MEM:  if (MEM_DONE) state_d = S_DECODE;
            S_DECODE: begin
                if (OPCODE[2:1] == 2'b11) state_d = S_E_SKIP;
                else if (IND)             state_d = S_D_MEM;
                else                      state_d = exec_entry(OPCODE);
            end
            S_D_MEM:  if (MEM_DONE) state_d = exec_entry(OPCODE);
            S_E_RD: begin
                if (MEM_DONE)
                    state_d = (OPCODE == 3'd2) ? S_E_WR : S_END;
            end
            S_E_WR: begin
                if (MEM_DONE) begin
                    if (OPCODE == 3'd2)      state_d = S_E_SKIP;
                    else if (OPCODE == 3'd4) state_d = S_E_PC1;
                    else                     state_d = S_END;
                end
            end
            S_E_PC1:  state_d = (OPCODE == 3'd4) ? S_E_GAP : S_END;
            S_E_GAP:  state_d = S_E_PC2;
            S_E_PC2:  state_d = S_END;
            S_E_SKIP: state_d = S_END;
            S_END: begin
                autorun_d = 1'b0;
                if (HALT_REQ || single_q || !run_eff) begin
                    state_d  = S_HALT;
                    single_d = 1'b0;
                end else begin
                    state_d  = S_F_PC;
                end
            end
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_HALT;
            single_q    <= 1'b0;
            autorun_q   <= AUTORUN;
            step_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            ir_ld_en_q  <= 1'b0;
            skip_en_q   <= 1'b0;
            pc_fetch_q  <= 1'b0;
            pc_ck_q     <= 1'b0;
            pc_ld_q     <= 1'b0;
            pc_latch_q  <= 1'b0;
            state_grp_q <= 2'b00;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            autorun_q   <= autorun_d;
            step_q      <= STEP;
            mem_req_q   <= state_d inside {S_F_MEM, S_D_MEM, S_E_RD, S_E_WR};
            mem_wr_q    <= (state_d == S_E_WR);
            ir_ld_en_q  <= (state_d == S_F_MEM);
            skip_en_q   <= (state_d == S_E_SKIP);
            pc_fetch_q  <= (state_d == S_F_PC);
            pc_ck_q     <= (state_d == S_E_PC2);
            pc_ld_q     <= (state_d == S_E_PC1);
            pc_latch_q  <= (state_d == S_E_PC2);
            state_grp_q <= state_grp(state_d);
            running_q   <= (state_d != S_HALT);
        end
    end

    // IR load and skip increment qualify a registered state flag with the
    // live datapath input, so they land in the cycle the condition is seen.
    assign MEM_REQ  = mem_req_q;
    assign MEM_WR   = mem_wr_q;
    assign IR_LD    = ir_ld_en_q & MEM_DONE;
    assign PC_FETCH = pc_fetch_q;
    assign PC_CK    = pc_ck_q | (skip_en_q & SKIP);
    assign PC_LD    = pc_ld_q;
    assign PC_LATCH = pc_latch_q;
    assign STATE    = state_grp_q;
    assign RUNNING  = running_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed test-plan flows plus randomized
// instruction streams against a per-instruction phase-list model.
module tb_instr_sequencer;

    logic       CLK = 1'b0;
    logic       RESET, RUN, STEP, HALT_REQ;
    logic [2:0] OPCODE;
    logic       IND, SKIP, MEM_DONE;
    logic       MEM_REQ, MEM_WR, IR_LD;
    logic       PC_FETCH, PC_CK, PC_LD, PC_LATCH;
    logic [1:0] STATE;
    logic       RUNNING;

    instr_sequencer dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
        .HALT_REQ(HALT_REQ), .OPCODE(OPCODE), .IND(IND), .SKIP(SKIP),
        .MEM_DONE(MEM_DONE), .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR),
        .IR_LD(IR_LD), .PC_FETCH(PC_FETCH), .PC_CK(PC_CK), .PC_LD(PC_LD),
        .PC_LATCH(PC_LATCH), .STATE(STATE), .RUNNING(RUNNING)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] grp;
        logic req, wr, irld, fetch, ck, ld, latch, mem, last;
    } step_t;

    step_t q[$];
    logic  m_single, m_prev_step;

    int n_cmp = 0, n_bad = 0;

    // stimulus policy
    logic       rnd = 0, junk = 0, rnd_dly = 0;
    logic       run_v = 0, step_v = 0, hreq_v = 0;
    logic [2:0] fop = 3'd5;
    logic       find = 0, fskip = 0;
    int         fix_dly = 0;

    // memory responder
    int   mcnt = 0, mdly = 0;
    logic mhit = 0;

    // per-window statistics
    int   cyc, fetch_n, ld_n, ck_n, latch_n, wr_n, d_n, halt_n;
    int   irld_at, ld_at;
    int   fetch_at [4];
    logic prev_strb = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {STATE, RUNNING, MEM_REQ, MEM_WR, IR_LD,
                PC_FETCH, PC_CK, PC_LD, PC_LATCH};
    endfunction

    task automatic push(input logic [1:0] g, input logic req, wr, irld,
                        fetch, ck, ld, latch, mem, last);
        step_t s;
        s = '{g, req, wr, irld, fetch, ck, ld, latch, mem, last};
        q.push_back(s);
    endtask

    // One instruction as the ordered list of major phases it must visit.
    task automatic build();
        logic [2:0] op;
        op = OPCODE;
        push(2'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(2'd1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        push(2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (op >= 3'd6) begin
            push(2'd3, 0, 0, 0, 0, SKIP, 0, 0, 0, 0);
        end else begin
            if (IND) push(2'd2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            if (op <= 3'd2) push(2'd3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
            if (op >= 3'd2 && op <= 3'd4)
                push(2'd3, 1, 1, 0, 0, 0, 0, 0, 1, 0);
            if (op == 3'd2) push(2'd3, 0, 0, 0, 0, SKIP, 0, 0, 0, 0);
            if (op >= 3'd4) push(2'd3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            if (op == 3'd4) begin
                push(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(2'd3, 0, 0, 0, 0, 1, 0, 1, 0, 0);
            end
        end
        push(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic advance();
        step_t cur;
        if (q.size() == 0) begin
            if (RUN) begin
                m_single = 0;
                build();
            end else if (STEP && !m_prev_step) begin
                m_single = 1;
                build();
            end
        end else begin
            cur = q[0];
            if (!(cur.mem && !MEM_DONE)) begin
                void'(q.pop_front());
                if (cur.last) begin
                    if (HALT_REQ || m_single || !RUN) m_single = 0;
                    else build();
                end
            end
        end
        m_prev_step = STEP;
    endtask

    task automatic model_reset();
        q.delete();
        m_single    = 0;
        m_prev_step = 0;
        prev_strb   = 0;
    endtask

    task automatic clear_stats();
        cyc = 0; fetch_n = 0; ld_n = 0; ck_n = 0; latch_n = 0;
        wr_n = 0; d_n = 0; halt_n = 0; irld_at = 0; ld_at = 0;
        foreach (fetch_at[i]) fetch_at[i] = 0;
    endtask

    task automatic tick();
        logic       dec, strb;
        logic [9:0] exp;
        @(negedge CLK);
        cyc++;
        if (!MEM_REQ) begin
            mcnt = 0;
            MEM_DONE = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            if (mhit) mcnt = 0;
            if (mcnt == 0) mdly = rnd_dly ? int'($urandom_range(0, 3)) : fix_dly;
            MEM_DONE = (mcnt == mdly);
            mcnt++;
        end
        mhit = MEM_REQ && MEM_DONE;
        dec = (q.size() == 0) || q[0].last;
        if (rnd) begin
            RUN = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 7) == 0) step_v = ~step_v;
        end else begin
            RUN = run_v;
        end
        STEP = step_v;
        if (dec) begin
            if (rnd) begin
                OPCODE   = 3'($urandom_range(0, 7));
                IND      = 1'($urandom_range(0, 1));
                SKIP     = 1'($urandom_range(0, 1));
                HALT_REQ = ($urandom_range(0, 9) == 0);
            end else begin
                OPCODE   = fop;
                IND      = find;
                SKIP     = fskip;
                HALT_REQ = hreq_v;
            end
        end else begin
            HALT_REQ = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        #1;
        if (q.size() == 0) exp = '0;
        else exp = {q[0].grp, 1'b1, q[0].req, q[0].wr, q[0].irld & MEM_DONE,
                    q[0].fetch, q[0].ck, q[0].ld, q[0].latch};
        chk("outs", 32'(outs()), 32'(exp));
        strb = PC_FETCH | PC_CK | PC_LD;
        if (strb) begin
            chk("pc_onehot", 32'($countones({PC_FETCH, PC_CK, PC_LD})), 32'd1);
            chk("pc_gap", 32'(prev_strb), 32'd0);
        end
        prev_strb = strb;
        if (PC_FETCH) begin
            if (fetch_n < 4) fetch_at[fetch_n] = cyc;
            fetch_n++;
        end
        if (PC_LD) begin
            if (ld_at == 0) ld_at = cyc;
            ld_n++;
        end
        if (IR_LD && irld_at == 0) irld_at = cyc;
        if (PC_CK) ck_n++;
        if (PC_LATCH) latch_n++;
        if (MEM_WR) wr_n++;
        if (STATE == 2'b10) d_n++;
        if (!RUNNING) halt_n++;
        advance();
    endtask

    task automatic sync();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 || q[0].last) break;
            tick();
        end
    endtask

    task automatic run_fetches(input string tag, input int n);
        for (int i = 0; i < 400 && fetch_n < n; i++) tick();
        chk(tag, 32'(fetch_n), 32'(n));
    endtask

    initial begin
        RESET = 1; RUN = 0; STEP = 0; HALT_REQ = 0;
        OPCODE = 3'd5; IND = 0; SKIP = 0; MEM_DONE = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1 chk("reset_outs", 32'(outs()), 32'd0);

        // JMP direct, memory answers immediately
        run_v = 1; RUN = 1;
        RESET = 0;
        model_reset();
        advance();
        clear_stats();
        repeat (6) tick();
        chk("jmp_fetch1", 32'(fetch_at[0]), 32'd1);
        chk("jmp_irld", 32'(irld_at), 32'd2);
        chk("jmp_ld", 32'(ld_at), 32'd4);
        chk("jmp_fetch2", 32'(fetch_at[1]), 32'd6);

        // DCA indirect, 3-cycle memory latency
        fop = 3'd3; find = 1; fix_dly = 3;
        sync(); clear_stats();
        run_fetches("dca_fetch", 2);
        chk("dca_defer_cyc", 32'(d_n), 32'd4);
        chk("dca_wr_cyc", 32'(wr_n), 32'd4);
        chk("dca_pc_strb", 32'(ck_n + ld_n), 32'd0);

        // ISZ with and without skip
        fop = 3'd2; find = 0; fskip = 1; fix_dly = 1;
        sync(); clear_stats();
        run_fetches("isz_fetch", 2);
        chk("isz_ck", 32'(ck_n), 32'd1);
        chk("isz_latch", 32'(latch_n), 32'd0);
        chk("isz_wr_cyc", 32'(wr_n), 32'd2);
        fskip = 0;
        sync(); clear_stats();
        run_fetches("isz0_fetch", 2);
        chk("isz0_ck", 32'(ck_n), 32'd0);

        // JMS
        fop = 3'd4; fix_dly = 0;
        sync(); clear_stats();
        run_fetches("jms_fetch", 2);
        chk("jms_ld", 32'(ld_n), 32'd1);
        chk("jms_ck", 32'(ck_n), 32'd1);
        chk("jms_latch", 32'(latch_n), 32'd1);
        chk("jms_wr", 32'(wr_n), 32'd1);

        // drop RUN, then single-step
        run_v = 0;
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        tick();
        chk("halt_on_run0", 32'(RUNNING), 32'd0);
        clear_stats();
        step_v = 1;
        repeat (20) tick();
        chk("step1_fetch", 32'(fetch_n), 32'd1);
        chk("step1_halted", 32'(RUNNING), 32'd0);
        step_v = 0;
        repeat (3) tick();
        step_v = 1;
        repeat (20) tick();
        chk("step2_fetch", 32'(fetch_n), 32'd2);
        step_v = 0;
        tick();

        // HALT_REQ at END while RUN stays high
        run_v = 1; hreq_v = 1; fop = 3'd5;
        clear_stats();
        repeat (12) tick();
        chk("hreq_halts", 32'(halt_n), 32'd2);
        chk("hreq_fetch", 32'(fetch_n), 32'd2);
        hreq_v = 0;

        // asynchronous reset in the middle of F_MEM
        fop = 3'd3; find = 0; fix_dly = 3;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (STATE == 2'b01 && MEM_REQ) break;
        end
        #1 RESET = 1;
        #1 chk("rst_async", 32'(outs()), 32'd0);
        RESET = 0;
        model_reset();
        advance();
        clear_stats();
        run_fetches("rst_restart", 2);
        chk("rst_first_fetch", 32'(fetch_at[0]), 32'd1);

        // randomized instruction stream
        rnd = 1; junk = 1; rnd_dly = 1;
        repeat (3000) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
